// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// ALUOp classes, instruction classes and the static-control bundle.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CL_R       = 4'd0,
    CL_I       = 4'd1,
    CL_LOAD    = 4'd2,
    CL_STORE   = 4'd3,
    CL_BRANCH  = 4'd4,
    CL_LUI     = 4'd5,
    CL_AUIPC   = 4'd6,
    CL_JAL     = 4'd7,
    CL_JALR    = 4'd8,
    CL_ILLEGAL = 4'd9
  } instr_class_e;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       lui_en;
    logic       auipc_en;
    logic       jal_en;
    logic       jalr_en;
  } ctrl_t;

  // Everything except register-register ALU ops and branches takes the immediate.
  function automatic ctrl_t class_ctrl(instr_class_e cls);
    ctrl_t c;
    c = '0;
    case (cls)
      CL_R:      c.alu_op = ALUOP_FUNCT;
      CL_I:      begin c.alu_src = 1'b1; c.alu_op = ALUOP_FUNCT; end
      CL_LOAD:   begin c.alu_src = 1'b1; c.mem_to_reg = 1'b1; end
      CL_STORE:  c.alu_src = 1'b1;
      CL_BRANCH: c.alu_op = ALUOP_BRANCH;
      CL_LUI:    begin c.alu_src = 1'b1; c.lui_en = 1'b1; end
      CL_AUIPC:  begin c.alu_src = 1'b1; c.auipc_en = 1'b1; end
      CL_JAL:    begin c.alu_src = 1'b1; c.jal_en = 1'b1; end
      CL_JALR:   begin c.alu_src = 1'b1; c.jalr_en = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_main_decoder.sv
// Combinational main decoder: opcode to instruction class plus static controls.
module mc_main_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7
) (
  input  logic [OPCODE_W-1:0] op,
  output instr_class_e        op_class,
  output ctrl_t               ctrl
);

  always_comb begin
    op_class = CL_ILLEGAL;
    case (op)
      OPCODE_W'(OP_R):      op_class = CL_R;
      OPCODE_W'(OP_I):      op_class = CL_I;
      OPCODE_W'(OP_LOAD):   op_class = CL_LOAD;
      OPCODE_W'(OP_STORE):  op_class = CL_STORE;
      OPCODE_W'(OP_BRANCH): op_class = CL_BRANCH;
      OPCODE_W'(OP_LUI):    op_class = CL_LUI;
      OPCODE_W'(OP_AUIPC):  op_class = CL_AUIPC;
      OPCODE_W'(OP_JAL):    op_class = CL_JAL;
      OPCODE_W'(OP_JALR):   op_class = CL_JALR;
      default:              op_class = CL_ILLEGAL;
    endcase
    ctrl = class_ctrl(op_class);
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes and illegal/timeout traps. Define MCU_PERF_CNT_EN for perf counters.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 7,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_jump,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                LUI_en,
  output logic                AUIPC_en,
  output logic                JAL_en,
  output logic                JALr_en,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                Branch,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic                trap,
  output logic                illegal_instr,
  output logic                bus_err,
  output logic [2:0]          state_o,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instret_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e              state_q, state_d, fetch_or_idle;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  instr_class_e        dec_class;
  ctrl_t               dec_ctrl, ctrl_q, ctrl_d;
  logic                waiting, timed_out;
  logic imem_req_q, imem_req_d, pc_jump_q, pc_jump_d, branch_q, branch_d;
  logic mem_read_q, mem_read_d, mem_write_q, mem_write_d, reg_write_q, reg_write_d;
  logic trap_q, trap_d, illegal_q, illegal_d, bus_err_q, bus_err_d;

  // The decoder sees the opcode being latched during DECODE so that the
  // registered controls are already valid on the first EXEC cycle.
  mc_main_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
    .op       (op_d),
    .op_class (dec_class),
    .ctrl     (dec_ctrl)
  );

  always_comb begin
    op_d          = (state_q == ST_DECODE) ? opcode : op_q;
    fetch_or_idle = enable ? ST_FETCH : ST_IDLE;
    waiting       = ((state_q == ST_FETCH) && !imem_ready) ||
                    ((state_q == ST_MEM) && !dmem_ready);
    timed_out     = (MEM_TIMEOUT != 0) && waiting &&
                    (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
    state_d       = state_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;

    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) state_d = ST_DECODE;
        else if (timed_out) begin
          state_d   = ST_TRAP;
          bus_err_d = 1'b1;
        end
      end
      ST_DECODE: begin
        if (dec_class == CL_ILLEGAL) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (dec_class)
          CL_BRANCH:         state_d = fetch_or_idle;
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ready) state_d = (dec_class == CL_LOAD) ? ST_WB : fetch_or_idle;
        else if (timed_out) begin
          state_d   = ST_TRAP;
          bus_err_d = 1'b1;
        end
      end
      ST_WB:     state_d = fetch_or_idle;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_IDLE;
    endcase

    wait_d = (state_d != state_q) ? '0 : (waiting ? wait_q + WAIT_W'(1) : wait_q);

    imem_req_d  = (state_d == ST_FETCH);
    branch_d    = (state_d == ST_EXEC) && (dec_class == CL_BRANCH);
    pc_jump_d   = (state_d == ST_EXEC) && ((dec_class == CL_JAL) || (dec_class == CL_JALR));
    mem_read_d  = (state_d == ST_MEM) && (dec_class == CL_LOAD);
    mem_write_d = (state_d == ST_MEM) && (dec_class == CL_STORE);
    reg_write_d = (state_d == ST_WB);
    trap_d      = (state_d == ST_TRAP);
    ctrl_d      = (state_d inside {ST_EXEC, ST_MEM, ST_WB}) ? dec_ctrl : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      wait_q      <= '0;
      ctrl_q      <= '0;
      imem_req_q  <= 1'b0;
      pc_jump_q   <= 1'b0;
      branch_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      trap_q      <= 1'b0;
      illegal_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wait_q      <= wait_d;
      ctrl_q      <= ctrl_d;
      imem_req_q  <= imem_req_d;
      pc_jump_q   <= pc_jump_d;
      branch_q    <= branch_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      trap_q      <= trap_d;
      illegal_q   <= illegal_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // IR and PC+4 updates follow the fetch ack combinationally.
  assign ir_write      = (state_q == ST_FETCH) && imem_ready;
  assign pc_write      = (state_q == ST_FETCH) && imem_ready;
  assign imem_req      = imem_req_q;
  assign pc_jump       = pc_jump_q;
  assign Branch        = branch_q;
  assign MemRead       = mem_read_q;
  assign MemWrite      = mem_write_q;
  assign RegWrite      = reg_write_q;
  assign trap          = trap_q;
  assign illegal_instr = illegal_q;
  assign bus_err       = bus_err_q;
  assign ALUSrc        = ctrl_q.alu_src;
  assign MemtoReg      = ctrl_q.mem_to_reg;
  assign ALUOp         = ALUOP_W'(ctrl_q.alu_op);
  assign LUI_en        = ctrl_q.lui_en;
  assign AUIPC_en      = ctrl_q.auipc_en;
  assign JAL_en        = ctrl_q.jal_en;
  assign JALr_en       = ctrl_q.jalr_en;
  assign state_o       = state_q;

`ifdef MCU_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, cycle_d, instret_q, instret_d;
  logic             retire;

  always_comb begin
    retire    = (state_q == ST_WB) ||
                ((state_q == ST_EXEC) && (dec_class == CL_BRANCH)) ||
                ((state_q == ST_MEM) && (dec_class == CL_STORE) && dmem_ready);
    cycle_d   = ((state_q != ST_IDLE) && (state_q != ST_TRAP)) ? cycle_q + CNT_W'(1) : cycle_q;
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
